// File: rtl/jedro_1_fetch_queue.sv
// Instruction fetch queue: buffers {pc, instr} pairs between fetch and decode,
// flags misaligned PCs and discards everything on a jump.
module jedro_1_fetch_queue #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic [DATA_WIDTH-1:0]      in_instr_i,
  input  logic [DATA_WIDTH-1:0]      in_pc_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  output logic [DATA_WIDTH-1:0]      out_instr_o,
  output logic [DATA_WIDTH-1:0]      out_pc_o,
  output logic                       out_misaligned_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] pc_mem    [DEPTH];
  logic                  mis_mem   [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  // Ready/valid come only from the count register, so no ready-to-ready path.
  assign in_ready_o  = (count != CNT_W'(DEPTH));
  assign out_valid_o = (count != '0);
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;
  assign count_o     = count;

  assign out_instr_o      = out_valid_o ? instr_mem[rd_ptr] : '0;
  assign out_pc_o         = out_valid_o ? pc_mem[rd_ptr]    : '0;
  assign out_misaligned_o = out_valid_o ? mis_mem[rd_ptr]   : 1'b0;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Storage is deliberately not reset; reads are masked by count instead.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) begin
      instr_mem[wr_ptr] <= in_instr_i;
      pc_mem[wr_ptr]    <= in_pc_i;
      mis_mem[wr_ptr]   <= (in_pc_i[1:0] != 2'b00);
    end
  end

endmodule

// File: tb/tb_jedro_1_fetch_queue.sv
// Self-checking bench for jedro_1_fetch_queue: directed plan plus random traffic
// compared against a queue-based reference model.
module tb_jedro_1_fetch_queue;

  localparam int DEPTH = 4;
  localparam int DW    = 32;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic [DW-1:0] in_instr_i;
  logic [DW-1:0] in_pc_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [DW-1:0] out_instr_o;
  logic [DW-1:0] out_pc_o;
  logic          out_misaligned_o;
  logic          out_valid_o;
  logic          out_ready_i;
  logic          flush_i;
  logic [2:0]    count_o;

  jedro_1_fetch_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .in_instr_i(in_instr_i), .in_pc_i(in_pc_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o),
    .out_instr_o(out_instr_o), .out_pc_o(out_pc_o),
    .out_misaligned_o(out_misaligned_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .flush_i(flush_i), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [DW-1:0] pc;
    logic [DW-1:0] instr;
  } ent_t;

  ent_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    ent_t h;
    logic [DW-1:0] e_pc, e_instr;
    logic e_mis;
    e_pc = '0; e_instr = '0; e_mis = 1'b0;
    if (q.size() != 0) begin
      h = q[0];
      e_pc = h.pc; e_instr = h.instr; e_mis = (h.pc[1:0] != 2'b00);
    end
    chk({tag, ".count"}, DW'(count_o), DW'(q.size()));
    chk({tag, ".valid"}, DW'(out_valid_o), DW'(q.size() != 0));
    chk({tag, ".ready"}, DW'(in_ready_o), DW'(q.size() != DEPTH));
    chk({tag, ".pc"}, out_pc_o, e_pc);
    chk({tag, ".instr"}, out_instr_o, e_instr);
    chk({tag, ".mis"}, DW'(out_misaligned_o), DW'(e_mis));
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] pc, input logic [DW-1:0] instr,
                       input logic rdy, input logic fl);
    in_valid_i = v; in_pc_i = pc; in_instr_i = instr; out_ready_i = rdy; flush_i = fl;
  endtask

  // One clock: model follows the queue rules at the edge, outputs checked at negedge.
  task automatic step(input string tag);
    bit do_pop, do_push;
    @(posedge clk_i);
    if (flush_i) begin
      q.delete();
    end else begin
      do_pop  = (q.size() != 0) && out_ready_i;
      do_push = in_valid_i && (q.size() != DEPTH);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back('{pc: in_pc_i, instr: in_instr_i});
    end
    @(negedge clk_i);
    check_all(tag);
  endtask

  initial begin
    logic [DW-1:0] pc;
    logic [DW-1:0] prev_pc;
    rstn_i = 1'b0;
    drive(0, '0, '0, 0, 0);
    repeat (2) @(negedge clk_i);
    check_all("reset");
    rstn_i = 1'b1;

    // mid-stream reset with three entries buffered
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h8000_0000 + 4*i, 32'hA0 + i, 0, 0);
      step("pre_rst");
    end
    #2 rstn_i = 1'b0;
    q.delete();
    #1 check_all("async_rst");
    drive(0, '0, '0, 0, 0);
    @(posedge clk_i);
    @(negedge clk_i);
    rstn_i = 1'b1;
    check_all("post_rst");

    // fill then drain; fifth push must be ignored
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h8000_0000 + 4*i, 32'h11 * (i + 1), 0, 0);
      step("fill");
    end
    chk("full.count", DW'(count_o), 32'd4);
    drive(1, 32'h8000_0010, 32'h55, 0, 0);
    step("fifth");
    for (int i = 0; i < 4; i++) begin
      chk("drain.instr", out_instr_o, 32'h11 * (i + 1));
      drive(0, '0, '0, 1, 0);
      step("drain");
    end
    chk("drained.valid", DW'(out_valid_o), 32'd0);

    // streaming with pointer wrap
    pc = 32'h8000_1000;
    prev_pc = '0;
    for (int i = 0; i < 20; i++) begin
      drive(1, pc, pc ^ 32'h5A5A_0000, 1, 0);
      step("stream");
      if (i > 0) chk("stream.inc", out_pc_o, prev_pc + 32'd4);
      prev_pc = out_pc_o;
      pc += 4;
    end
    drive(0, '0, '0, 1, 0);
    step("stream_end");

    // flush on a full queue with concurrent push and pop
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h8000_0040 + 4*i, 32'h70 + i, 0, 0);
      step("fill2");
    end
    drive(1, 32'h8000_0100, 32'hDEAD, 1, 1);
    step("flush");
    chk("flush.count", DW'(count_o), 32'd0);
    drive(1, 32'h8000_0200, 32'hBEEF, 0, 0);
    step("post_flush");
    chk("post_flush.pc", out_pc_o, 32'h8000_0200);
    drive(0, '0, '0, 1, 0);
    step("post_flush_pop");

    // misalignment flag
    drive(1, 32'h8000_0006, 32'h66, 0, 0);
    step("mis_push1");
    drive(1, 32'h8000_0008, 32'h88, 0, 0);
    step("mis_push2");
    chk("mis.head", DW'(out_misaligned_o), 32'd1);
    drive(0, '0, '0, 1, 0);
    step("mis_pop");
    chk("mis.next", DW'(out_misaligned_o), 32'd0);
    step("mis_pop2");

    // full boundary: pop and push together while full
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h8000_0300 + 4*i, 32'h90 + i, 0, 0);
      step("fill3");
    end
    drive(1, 32'h8000_0400, 32'h99, 1, 0);
    step("full_pp");
    chk("full_pp.count", DW'(count_o), 32'd3);
    chk("full_pp.ready", DW'(in_ready_o), 32'd1);
    drive(0, '0, '0, 0, 1);
    step("clr");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, $urandom,
            1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
